// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcodes, and the datapath select codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath:
// opcode/mem_ready flow in, every select and enable flows out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write,
        output ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
        output alu_src_b, alu_op, pc_source, instr_done, illegal_op,
        output state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write,
        input  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
        input  alu_src_b, alu_op, pc_source, instr_done, illegal_op,
        input  state
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational map from FSM state (plus mem_ready and opcode legality)
// to the full datapath control vector.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ASB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ASB_IMM_SH;
                if (!op_legal(opcode)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: state register and next-state logic;
// control outputs come from mips_ctrl_decode.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t state_q;
    state_t state_d;
    logic   is_lw_q;
    ctrl_t  c;

    mips_ctrl_decode u_dec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .opcode    (bus.opcode),
        .ctrl      (c)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Opcode is only valid in DECODE, so remember lw vs sw for MEM_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                is_lw_q <= (bus.opcode == OP_LW);
        end
    end

    assign bus.pc_write      = c.pc_write;
    assign bus.pc_write_cond = c.pc_write_cond;
    assign bus.iord          = c.iord;
    assign bus.mem_read      = c.mem_read;
    assign bus.mem_write     = c.mem_write;
    assign bus.ir_write      = c.ir_write;
    assign bus.mem_to_reg    = c.mem_to_reg;
    assign bus.reg_dst       = c.reg_dst;
    assign bus.reg_write     = c.reg_write;
    assign bus.alu_src_a     = c.alu_src_a;
    assign bus.alu_src_b     = c.alu_src_b;
    assign bus.alu_op        = c.alu_op;
    assign bus.pc_source     = c.pc_source;
    assign bus.instr_done    = c.instr_done;
    assign bus.illegal_op    = c.illegal_op;
    assign bus.state         = state_q;

endmodule
